// File: rtl/mem_stream_port_pkg.sv
// Shared definitions for the RAM streaming port: width helper and FSM state encoding.
`ifndef MSP_CLOG2
`define MSP_CLOG2(x) $clog2(x)
`endif

package mem_stream_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int FIFO_ENTRIES = 2;

endpackage

// File: rtl/mem_stream_port_fifo2.sv
// Two-entry valid/ready FIFO with a registered head word; absorbs RAM read latency on DRAIN.
module stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_wr_valid,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [1:0]       o_count
);
  import mem_stream_port_pkg::*;

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_cnt;
  logic             w_wr_ready;
  logic             w_push;
  logic             w_pop;

  assign o_rd_valid = (r_cnt != 2'd0);
  assign o_rd_data  = r_head;
  assign o_count    = r_cnt;
  assign w_pop      = o_rd_valid & i_rd_ready;
  assign w_wr_ready = (r_cnt != 2'(FIFO_ENTRIES)) || i_rd_ready;
  assign w_push     = i_wr_valid & w_wr_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 2'd0;
    end else begin
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  // Storage: a pop shifts the tail into the head; a push lands in the first free slot.
  always_ff @(posedge i_clk) begin
    if (w_pop) begin
      if (r_cnt == 2'd2) begin
        r_head <= r_tail;
        if (w_push) r_tail <= i_wr_data;
      end else if (w_push) begin
        r_head <= i_wr_data;
      end
    end else if (w_push) begin
      if (r_cnt == 2'd0) r_head <= i_wr_data;
      else               r_tail <= i_wr_data;
    end
  end

endmodule

// File: rtl/mem_stream_port.sv
// Streaming FILL/DRAIN front-end for a single-port synchronous RAM with 1-cycle read latency.
module mem_stream_port
  import mem_stream_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = `MSP_CLOG2(DEPTH),
  localparam int LW = `MSP_CLOG2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_drain,
  input  logic [AW-1:0]    cmd_base,
  input  logic [LW-1:0]    cmd_len,
  output logic             busy,
  output logic             done,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mem_data,
  output logic [AW-1:0]    mem_address,
  output logic             mem_wr_en,
  input  logic [WIDTH-1:0] mem_q
);

  state_t           r_state;
  logic [AW-1:0]    r_cur;
  logic [LW-1:0]    r_rem;
  logic             r_inflight;
  logic             r_busy;
  logic             r_done;

  logic [AW-1:0]    w_base;
  logic [AW-1:0]    w_cur_nxt;
  logic             w_words_left;
  logic             w_wr;
  logic             w_rd;
  logic             w_pop;
  logic             w_room;
  logic             w_drain_end;
  logic [2:0]       w_occ;
  logic [1:0]       w_fifo_cnt;
  logic [WIDTH-1:0] w_fifo_data;
  logic             w_fifo_valid;

  // cmd_base never exceeds 2*DEPTH-1, so a single conditional subtract is a full modulo.
  assign w_base    = (int'(cmd_base) >= DEPTH) ? AW'(int'(cmd_base) - DEPTH) : cmd_base;
  assign w_cur_nxt = (r_cur == AW'(DEPTH - 1)) ? '0 : r_cur + AW'(1);

  assign w_words_left = (r_rem != '0);
  assign in_ready     = (r_state == ST_FILL) && w_words_left;
  assign w_wr         = in_ready && in_valid;

  // Credit check counts the word leaving this cycle so back-to-back reads sustain full rate.
  assign w_pop       = w_fifo_valid & out_ready;
  assign w_occ       = {1'b0, w_fifo_cnt} + {2'b00, r_inflight};
  assign w_room      = (w_occ < 3'd2) || (w_pop && (w_occ == 3'd2));
  assign w_rd        = (r_state == ST_DRAIN) && w_words_left && w_room;
  assign w_drain_end = !w_words_left && !r_inflight &&
                       ((w_fifo_cnt == 2'd0) || ((w_fifo_cnt == 2'd1) && w_pop));

  assign mem_wr_en   = w_wr;
  assign mem_data    = w_wr ? in_data : '0;
  assign mem_address = (w_wr || w_rd) ? r_cur : '0;

  assign out_valid = w_fifo_valid;
  assign out_data  = w_fifo_valid ? w_fifo_data : '0;
  assign busy      = r_busy;
  assign done      = r_done;

  stream_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .i_clk      (clock),
    .i_rst      (rst),
    .i_wr_data  (mem_q),
    .i_wr_valid (r_inflight),
    .o_rd_data  (w_fifo_data),
    .o_rd_valid (w_fifo_valid),
    .i_rd_ready (out_ready),
    .o_count    (w_fifo_cnt)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_rd;
      case (r_state)
        ST_IDLE: begin
          if (cmd_start) begin
            r_cur  <= w_base;
            r_rem  <= cmd_len;
            r_busy <= 1'b1;
            if (cmd_len == '0)  r_state <= ST_FINISH;
            else if (cmd_drain) r_state <= ST_DRAIN;
            else                r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_wr) begin
            r_cur <= w_cur_nxt;
            r_rem <= r_rem - LW'(1);
            if (r_rem == LW'(1)) r_state <= ST_FINISH;
          end
        end
        ST_DRAIN: begin
          if (w_rd) begin
            r_cur <= w_cur_nxt;
            r_rem <= r_rem - LW'(1);
          end
          if (w_drain_end) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_port.sv
// Directed bench for mem_stream_port: DEPTH=64 and DEPTH=48 instances share stimulus, each with its own RAM.
module tb_mem_stream_port;

  logic       clock = 1'b0;
  logic       rst, cmd_start, cmd_drain, in_valid, out_ready;
  logic [5:0] cmd_base;
  logic [6:0] cmd_len;
  logic [7:0] in_data;

  always #5 clock = ~clock;

  logic       a_busy, a_done, a_in_ready, a_out_valid, a_wr;
  logic [7:0] a_out_data, a_mdata, a_q;
  logic [5:0] a_addr;
  logic       b_busy, b_done, b_in_ready, b_out_valid, b_wr;
  logic [7:0] b_out_data, b_mdata, b_q;
  logic [5:0] b_addr;

  mem_stream_port #(.WIDTH(8), .DEPTH(64)) dut64 (
    .clock(clock), .rst(rst), .cmd_start(cmd_start), .cmd_drain(cmd_drain),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .busy(a_busy), .done(a_done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .mem_data(a_mdata), .mem_address(a_addr), .mem_wr_en(a_wr), .mem_q(a_q));

  mem_stream_port #(.WIDTH(8), .DEPTH(48)) dut48 (
    .clock(clock), .rst(rst), .cmd_start(cmd_start), .cmd_drain(cmd_drain),
    .cmd_base(cmd_base), .cmd_len(cmd_len[5:0]), .busy(b_busy), .done(b_done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .mem_data(b_mdata), .mem_address(b_addr), .mem_wr_en(b_wr), .mem_q(b_q));

  // RAM models: 1-cycle read latency, write-through q
  logic [7:0] ram_a [64];
  logic [7:0] ram_b [48];
  always @(posedge clock) begin
    if (a_wr) ram_a[a_addr] <= a_mdata;
    a_q <= a_wr ? a_mdata : ram_a[a_addr];
    if (b_wr && b_addr < 6'd48) ram_b[b_addr] <= b_mdata;
    b_q <= b_wr ? b_mdata : ((b_addr < 6'd48) ? ram_b[b_addr] : 8'h00);
  end

  logic       sel;
  logic       o_busy, o_done, o_in_ready, o_out_valid, o_wr;
  logic [7:0] o_out_data, o_mdata;
  logic [5:0] o_addr;
  always_comb begin
    o_busy      = sel ? b_busy      : a_busy;
    o_done      = sel ? b_done      : a_done;
    o_in_ready  = sel ? b_in_ready  : a_in_ready;
    o_out_valid = sel ? b_out_valid : a_out_valid;
    o_wr        = sel ? b_wr        : a_wr;
    o_out_data  = sel ? b_out_data  : a_out_data;
    o_mdata     = sel ? b_mdata     : a_mdata;
    o_addr      = sel ? b_addr      : a_addr;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] src[$];
  logic [7:0] got_out[$];
  int         wr_addr[$];
  logic [7:0] wr_dat[$];
  int         exp_addr[$];
  logic [7:0] exp_dat[$];
  int         done_k, n_done, first_out_k;
  logic       last_busy;

  function automatic logic rdy(input int pat, input int k);
    case (pat)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_cmd(input bit s, input bit drain, input int base, input int len,
                         input int pat, input int poke_k, input int max_k);
    int         si;
    bit         hs_in, prev_stall;
    logic [7:0] prev_data;
    sel = s;
    got_out.delete(); wr_addr.delete(); wr_dat.delete();
    si = 0; done_k = -1; n_done = 0; first_out_k = -1; prev_stall = 0; prev_data = 8'h00;
    @(posedge clock); #1;
    cmd_start = 1'b1; cmd_drain = drain; cmd_base = 6'(base); cmd_len = 7'(len);
    for (int k = 0; k < max_k; k++) begin
      in_valid  = !drain && (si < src.size());
      in_data   = in_valid ? src[si] : 8'h00;
      out_ready = rdy(pat, k);
      if (k == poke_k) begin
        cmd_start = 1'b1; cmd_drain = 1'b1; cmd_base = 6'd30; cmd_len = 7'd5;
      end
      @(negedge clock);
      if (prev_stall) begin
        chk("hold_valid", o_out_valid, 1'b1);
        chk("hold_data", o_out_data, prev_data);
      end
      prev_stall = o_out_valid && !out_ready;
      prev_data  = o_out_data;
      chk("wr_needs_handshake", o_wr, in_valid & o_in_ready);
      if (o_wr) begin
        wr_addr.push_back(int'(o_addr));
        wr_dat.push_back(o_mdata);
      end
      if (o_out_valid && out_ready) begin
        got_out.push_back(o_out_data);
        if (first_out_k < 0) first_out_k = k;
      end
      if (o_done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      last_busy = o_busy;
      hs_in = in_valid && o_in_ready;
      @(posedge clock); #1;
      cmd_start = 1'b0;
      if (hs_in) si++;
    end
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
  endtask

  task automatic chk_writes(input string t);
    chk({t, "_nwr"}, wr_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      chk({t, "_addr"}, wr_addr[i], exp_addr[i]);
      chk({t, "_data"}, wr_dat[i], exp_dat[i]);
    end
  endtask

  task automatic chk_outs(input string t);
    chk({t, "_nout"}, got_out.size(), exp_dat.size());
    for (int i = 0; i < exp_dat.size() && i < got_out.size(); i++)
      chk({t, "_data"}, got_out[i], exp_dat[i]);
  endtask

  initial begin
    rst = 1'b1; cmd_start = 1'b0; cmd_drain = 1'b0; cmd_base = '0; cmd_len = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; last_busy = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_in_ready", o_in_ready, 1'b0);
    chk("rst_out_valid", o_out_valid, 1'b0);
    chk("rst_wr_en", o_wr, 1'b0);
    chk("rst_addr", o_addr, 6'd0);
    chk("rst_out_data", o_out_data, 8'h00);
    sel = 1'b1; #1;
    chk("rst48_busy", o_busy, 1'b0);
    chk("rst48_in_ready", o_in_ready, 1'b0);
    sel = 1'b0;
    @(posedge clock); #1;
    rst = 1'b0;

    // FILL 0..3 with a second cmd_start poked while busy
    src = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_cmd(0, 0, 0, 4, 0, 2, 10);
    exp_addr = {0, 1, 2, 3}; exp_dat = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    chk_writes("fill0");
    chk("fill0_done_k", done_k, 6);
    chk("fill0_ndone", n_done, 1);
    chk("fill0_idle", last_busy, 1'b0);

    src.delete();
    run_cmd(0, 1, 0, 4, 0, -1, 12);
    chk_outs("drain0");
    chk("drain0_first", first_out_k, 3);
    chk("drain0_done_k", done_k, 8);
    chk("drain0_ndone", n_done, 1);
    chk("drain0_nwr", wr_addr.size(), 0);

    src = {8'h11, 8'h22, 8'h33, 8'h44};
    run_cmd(0, 0, 62, 4, 0, -1, 10);
    exp_addr = {62, 63, 0, 1}; exp_dat = {8'h11, 8'h22, 8'h33, 8'h44};
    chk_writes("fillwrap");
    chk("fillwrap_done_k", done_k, 6);

    src.delete();
    run_cmd(0, 1, 62, 4, 1, -1, 30);
    chk_outs("drainstall");
    chk("drainstall_first", first_out_k, 3);
    chk("drainstall_ndone", n_done, 1);
    chk("drainstall_nwr", wr_addr.size(), 0);
    chk("drainstall_idle", last_busy, 1'b0);

    src = {8'h77};
    run_cmd(0, 0, 5, 0, 0, -1, 6);
    chk("len0f_done_k", done_k, 2);
    chk("len0f_nwr", wr_addr.size(), 0);
    chk("len0f_ndone", n_done, 1);
    src.delete();
    run_cmd(0, 1, 5, 0, 0, -1, 6);
    chk("len0d_done_k", done_k, 2);
    chk("len0d_nout", got_out.size(), 0);

    src = {8'h5A, 8'h6B, 8'h7C};
    run_cmd(1, 0, 46, 3, 0, -1, 8);
    exp_addr = {46, 47, 0}; exp_dat = {8'h5A, 8'h6B, 8'h7C};
    chk_writes("d48wrap");
    chk("d48wrap_done_k", done_k, 5);
    src = {8'h99};
    run_cmd(1, 0, 50, 1, 0, -1, 6);
    exp_addr = {2}; exp_dat = {8'h99};
    chk_writes("d48base");
    chk("d48base_done_k", done_k, 3);

    // Reset while two words sit in the output buffer
    sel = 1'b0;
    @(posedge clock); #1;
    cmd_start = 1'b1; cmd_drain = 1'b1; cmd_base = 6'd0; cmd_len = 7'd4; out_ready = 1'b0;
    @(posedge clock); #1;
    cmd_start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rstmid_valid", o_out_valid, 1'b1);
    chk("rstmid_data", o_out_data, 8'h33);
    chk("rstmid_busy", o_busy, 1'b1);
    @(posedge clock); #1;
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    chk("rstpost_valid", o_out_valid, 1'b0);
    chk("rstpost_busy", o_busy, 1'b0);
    chk("rstpost_done", o_done, 1'b0);
    n_done = 0;
    repeat (4) begin
      @(negedge clock);
      if (o_done) n_done++;
    end
    chk("rstpost_nodone", n_done, 0);

    src = {8'hE5, 8'hF6};
    run_cmd(0, 0, 10, 2, 0, -1, 8);
    exp_addr = {10, 11}; exp_dat = {8'hE5, 8'hF6};
    chk_writes("refill");
    chk("refill_done_k", done_k, 4);
    src.delete();
    run_cmd(0, 1, 10, 2, 0, -1, 10);
    chk_outs("redrain");
    chk("redrain_done_k", done_k, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
